scarv_cop_malu_seq: RTL and testbench

//  Multi-cycle multi-precision ALU sequencer for the SCARV coprocessor (COP).

---
 rtl/scarv_cop_malu_seq.sv | 144 ++++++++++++++
 tb/tb_scarv_cop_malu_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_malu_seq.sv
// Multi-cycle multi-precision ALU sequencer for the SCARV coprocessor.
// Accepts one MP instruction per ivalid/idone handshake. It computes a 64-bit
// {hi,lo} result (add/sub with carry, 64-bit shift, or 32x32+32 shift-add
// multiply), writes lo and then hi back to the CPR file, and pulses idone.
// Ports:
//   g_clk, g_resetn          clock, async active-low reset
//   malu_flush               abort current instruction
//   malu_ivalid              instruction valid (held until idone)
//   malu_rs1/rs2/rs3         source operands
//   id_imm, id_subclass      immediate shamt, op select [2:0], shamt-from-imm [3]
//   malu_busy                high whenever not idle
//   malu_idone               one-cycle completion pulse
//   malu_rd_wen/wsel/wdata   CPR writeback (wsel 0 = lo, 1 = hi)
module scarv_cop_malu_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        malu_flush,
  input  logic        malu_ivalid,
  input  logic [31:0] malu_rs1,
  input  logic [31:0] malu_rs2,
  input  logic [31:0] malu_rs3,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_subclass,
  output logic        malu_busy,
  output logic        malu_idone,
  output logic        malu_rd_wen,
  output logic        malu_rd_wsel,
  output logic [31:0] malu_rd_wdata
);

  typedef enum logic [2:0] {StIdle, StMul, StWrLo, StWrHi, StNowb} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] rs1_q;

  logic [5:0]  sh;
  logic [32:0] arith;
  logic [63:0] op_res;
  logic [32:0] mul_sum;
  logic [63:0] acc_step;

  logic unused_bits;
  assign unused_bits = ^{id_imm[31:6], id_subclass[31:4]};

  // Single-cycle results for ops 0-3, computed from the live (held) operands.
  always_comb begin
    sh     = id_subclass[3] ? id_imm[5:0] : malu_rs3[5:0];
    arith  = 33'd0;
    op_res = 64'd0;
    case (id_subclass[2:0])
      3'd0: begin
        arith  = {1'b0, malu_rs1} + {1'b0, malu_rs2} + {32'd0, malu_rs3[0]};
        op_res = {31'd0, arith[32], arith[31:0]};
      end
      3'd1: begin
        // Bit 32 of the 33-bit difference is the borrow out.
        arith  = {1'b0, malu_rs1} - {1'b0, malu_rs2} - {32'd0, malu_rs3[0]};
        op_res = {31'd0, arith[32], arith[31:0]};
      end
      3'd2:    op_res = {malu_rs2, malu_rs1} << sh;
      3'd3:    op_res = {malu_rs2, malu_rs1} >> sh;
      default: op_res = 64'd0;
    endcase
  end

  // Shift-add step: acc = {partial hi, remaining multiplier}. Seeding hi with
  // rs3 folds the addend in, since it is shifted down 32 times by the end.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, rs1_q} : 33'd0);
    acc_step = {mul_sum, acc_q[31:1]};
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q       <= StIdle;
      cnt_q         <= 5'd0;
      acc_q         <= 64'd0;
      rs1_q         <= 32'd0;
      malu_busy     <= 1'b0;
      malu_idone    <= 1'b0;
      malu_rd_wen   <= 1'b0;
      malu_rd_wsel  <= 1'b0;
      malu_rd_wdata <= 32'd0;
    end else begin
      malu_idone    <= 1'b0;
      malu_rd_wen   <= 1'b0;
      malu_rd_wsel  <= 1'b0;
      malu_rd_wdata <= 32'd0;
      if (malu_flush) begin
        state_q   <= StIdle;
        malu_busy <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (malu_ivalid) begin
              malu_busy <= 1'b1;
              case (id_subclass[2:0])
                3'd0, 3'd1, 3'd2, 3'd3: begin
                  acc_q         <= op_res;
                  state_q       <= StWrLo;
                  malu_rd_wen   <= 1'b1;
                  malu_rd_wdata <= op_res[31:0];
                end
                3'd4: begin
                  acc_q   <= {malu_rs3, malu_rs2};
                  rs1_q   <= malu_rs1;
                  cnt_q   <= 5'd0;
                  state_q <= StMul;
                end
                default: begin
                  state_q    <= StNowb;
                  malu_idone <= 1'b1;
                end
              endcase
            end
          end
          StMul: begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q       <= StWrLo;
              malu_rd_wen   <= 1'b1;
              malu_rd_wdata <= acc_step[31:0];
            end
          end
          StWrLo: begin
            state_q       <= StWrHi;
            malu_rd_wen   <= 1'b1;
            malu_rd_wsel  <= 1'b1;
            malu_rd_wdata <= acc_q[63:32];
            malu_idone    <= 1'b1;
          end
          default: begin
            state_q   <= StIdle;
            malu_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scarv_cop_malu_seq.sv
module tb_scarv_cop_malu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, ivalid;
  logic [31:0] rs1, rs2, rs3, imm, subclass;
  logic        busy, idone, wen, wsel;
  logic [31:0] wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scarv_cop_malu_seq dut (
    .g_clk        (clk),
    .g_resetn     (rst_n),
    .malu_flush   (flush),
    .malu_ivalid  (ivalid),
    .malu_rs1     (rs1),
    .malu_rs2     (rs2),
    .malu_rs3     (rs3),
    .id_imm       (imm),
    .id_subclass  (subclass),
    .malu_busy    (busy),
    .malu_idone   (idone),
    .malu_rd_wen  (wen),
    .malu_rd_wsel (wsel),
    .malu_rd_wdata(wdata)
  );

  typedef struct {
    logic [2:0]  op;
    logic        imm_sh;
    logic [31:0] a, b, c, im;
    logic [31:0] lo, hi;
    logic        wb;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  // {busy, idone, rd_wen, rd_wsel, rd_wdata}
  function automatic logic [35:0] obs();
    return {busy, idone, wen, wsel, wdata};
  endfunction

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy/idone/wen/wsel=%b wdata=%h, expected %b wdata=%h",
               name, got[35:32], got[31:0], exp[35:32], exp[31:0]);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic imm_sh,
                       input logic [31:0] a, b, c, im);
    rs1      = a;
    rs2      = b;
    rs3      = c;
    imm      = im;
    subclass = {28'h5A5A5A5, imm_sh, op};
    ivalid   = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_vec(input int idx, input vec_t v);
    logic [35:0] e;
    drive(v.op, v.imm_sh, v.a, v.b, v.c, v.im);
    @(posedge clk);
    for (int k = 1; k <= v.lat + 1; k++) begin
      @(negedge clk);
      e[35] = (k <= v.lat);
      e[34] = (k == v.lat);
      e[33] = v.wb && (k == v.lat - 1 || k == v.lat);
      e[32] = v.wb && (k == v.lat);
      e[31:0] = !v.wb ? 32'd0 : (k == v.lat - 1) ? v.lo : (k == v.lat) ? v.hi : 32'd0;
      chk($sformatf("vec%0d cycle T+%0d", idx, k), obs(), e);
      if (k == v.lat) ivalid = 1'b0;
    end
  endtask

  initial begin
    int seen;
    vecs[0]  = '{3'd0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'd0, 32'h00000001, 32'h00000001, 1'b1, 2};
    vecs[1]  = '{3'd1, 1'b0, 32'h00000000, 32'h00000001, 32'h00000000, 32'd0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 2};
    vecs[2]  = '{3'd2, 1'b0, 32'h80000000, 32'h00000001, 32'h00000001, 32'd0, 32'h00000000, 32'h00000003, 1'b1, 2};
    vecs[3]  = '{3'd2, 1'b0, 32'h80000000, 32'h00000001, 32'h00000000, 32'd0, 32'h80000000, 32'h00000001, 1'b1, 2};
    vecs[4]  = '{3'd2, 1'b1, 32'h80000000, 32'h00000001, 32'h00000005, 32'd63, 32'h00000000, 32'h00000000, 1'b1, 2};
    vecs[5]  = '{3'd3, 1'b0, 32'h80000000, 32'h00000001, 32'h00000004, 32'd0, 32'h18000000, 32'h00000000, 1'b1, 2};
    vecs[6]  = '{3'd3, 1'b1, 32'h00000000, 32'h80000000, 32'h00000000, 32'd63, 32'h00000001, 32'h00000000, 1'b1, 2};
    vecs[7]  = '{3'd0, 1'b0, 32'h00000001, 32'h00000002, 32'h00000002, 32'd0, 32'h00000003, 32'h00000000, 1'b1, 2};
    vecs[8]  = '{3'd1, 1'b0, 32'h00000005, 32'h00000003, 32'h00000001, 32'd0, 32'h00000001, 32'h00000000, 1'b1, 2};
    vecs[9]  = '{3'd4, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h00000000, 32'hFFFFFFFF, 1'b1, 34};
    vecs[10] = '{3'd4, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'd0, 32'h23456781, 32'h00000001, 1'b1, 34};
    vecs[11] = '{3'd6, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'd0, 32'h00000000, 32'h00000000, 1'b0, 1};

    rst_n = 1'b0; flush = 1'b0; ivalid = 1'b0;
    rs1 = 32'd0; rs2 = 32'd0; rs3 = 32'd0; imm = 32'd0; subclass = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset state", obs(), 36'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // MMUL flushed at T+10: idle at T+11, never writes or completes.
    drive(3'd4, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    @(posedge clk);
    repeat (10) @(negedge clk);
    chk("mmul busy at T+10", obs(), {4'b1000, 32'd0});
    flush = 1'b1; ivalid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush idle at T+11", obs(), 36'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wen || idone || busy) seen++;
    end
    chk("no activity after flush", {4'd0, 32'(seen)}, 36'd0);
    run_vec(100, vecs[0]);

    // Flush together with ivalid in IDLE: not accepted.
    drive(3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ivalid = 1'b0;
    chk("flush+ivalid not accepted", obs(), 36'd0);
    @(negedge clk);
    chk("flush+ivalid still idle", obs(), 36'd0);

    // Flush coinciding with WRLO: lo written, hi and idone suppressed.
    drive(3'd0, 1'b0, 32'h00000010, 32'h00000020, 32'h00000001, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("wrlo before flush", obs(), {4'b1010, 32'h00000031});
    flush = 1'b1; ivalid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("hi suppressed by flush", obs(), 36'd0);

    // Reset asserted at T+5 of MMUL.
    drive(3'd4, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    @(posedge clk);
    repeat (5) @(negedge clk);
    chk("mmul busy at T+5", obs(), {4'b1000, 32'd0});
    rst_n = 1'b0;
    #1;
    chk("async reset mid-mmul", obs(), 36'd0);
    ivalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset release", obs(), 36'd0);
    run_vec(101, vecs[10]);

    // Back-to-back MADD then MSRL with ivalid held high throughout.
    drive(3'd0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b madd lo", obs(), {4'b1010, 32'h00000001});
    @(negedge clk);
    chk("b2b madd hi", obs(), {4'b1111, 32'h00000001});
    drive(3'd3, 1'b0, 32'h00000000, 32'h0000000F, 32'h00000004, 32'd0);
    @(negedge clk);
    chk("b2b idle gap", obs(), 36'd0);
    @(negedge clk);
    chk("b2b msrl lo", obs(), {4'b1010, 32'hF0000000});
    @(negedge clk);
    chk("b2b msrl hi", obs(), {4'b1111, 32'h00000000});
    ivalid = 1'b0;
    @(negedge clk);
    chk("b2b done idle", obs(), 36'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
